// File: rtl/cordic_vector_iter.sv
// Iterative circular CORDIC in vectoring mode: (x, y) -> (magnitude, atan2(y, x)).
// A single shift-add stage is reused for every micro-rotation under a small FSM.
module cordic_vector_iter #(
  parameter int N_ITERATION     = 12,
  parameter int INTEGER_BITS    = 3,
  parameter int FRACTIONAL_BITS = 30,
  parameter int BITS            = INTEGER_BITS + FRACTIONAL_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic signed [BITS-1:0] i_x,
  input  logic signed [BITS-1:0] i_y,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic signed [BITS-1:0] o_mag,
  output logic signed [BITS-1:0] o_angle
);

  localparam int CW = (N_ITERATION > 1) ? $clog2(N_ITERATION) : 1;

  typedef enum logic [2:0] {IDLE, PRE, ITER, SCALE, DONE} state_t;

  function automatic real fix_scale();
    real s;
    s = 1.0;
    for (int k = 0; k < FRACTIONAL_BITS; k++) s = s * 2.0;
    return s;
  endfunction

  function automatic logic signed [BITS-1:0] to_fix(input real r);
    return BITS'(longint'(r * fix_scale()));
  endfunction

  // atan(2^-i) by its Taylor series; t <= 0.5 for i >= 1 so 40 terms is far beyond precision.
  function automatic real atan_pow2(input int i);
    real t, term, sum;
    if (i == 0) return 0.7853981633974483;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t * 0.5;
    term = t;
    sum  = 0.0;
    for (int k = 0; k < 40; k++) begin
      sum  = sum + (((k % 2) == 1) ? -1.0 : 1.0) * term / real'(2 * k + 1);
      term = term * t * t;
    end
    return sum;
  endfunction

  localparam logic signed [BITS-1:0]   K_FIX   = to_fix(0.6072529350088812);
  localparam logic signed [BITS-1:0]   HALF_PI = to_fix(1.5707963267948966);
  localparam logic signed [2*BITS-1:0] K_WIDE  = {{BITS{K_FIX[BITS-1]}}, K_FIX};

  logic signed [BITS-1:0] atan_tab [N_ITERATION];

  genvar gi;
  generate
    for (gi = 0; gi < N_ITERATION; gi++) begin : g_atan
      localparam logic signed [BITS-1:0] ATAN_I = to_fix(atan_pow2(gi));
      assign atan_tab[gi] = ATAN_I;
    end
  endgenerate

  state_t                 state_reg;
  logic signed [BITS-1:0] x_reg;
  logic signed [BITS-1:0] y_reg;
  logic signed [BITS-1:0] z_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   zero_reg;
  logic                   valid_reg;
  logic signed [BITS-1:0] mag_reg;
  logic signed [BITS-1:0] angle_reg;

  logic                     accept;
  logic signed [BITS-1:0]   x_sh;
  logic signed [BITS-1:0]   y_sh;
  logic signed [2*BITS-1:0] x_wide;
  logic signed [2*BITS-1:0] prod;

  assign o_ready = (state_reg == IDLE) && i_rst_n;
  assign accept  = i_valid && o_ready;
  assign o_valid = valid_reg;
  assign o_mag   = mag_reg;
  assign o_angle = angle_reg;

  assign x_sh   = x_reg >>> cnt_reg;
  assign y_sh   = y_reg >>> cnt_reg;
  assign x_wide = {{BITS{x_reg[BITS-1]}}, x_reg};
  assign prod   = x_wide * K_WIDE;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      cnt_reg   <= '0;
      zero_reg  <= 1'b0;
      valid_reg <= 1'b0;
      mag_reg   <= '0;
      angle_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            x_reg     <= i_x;
            y_reg     <= i_y;
            z_reg     <= '0;
            zero_reg  <= (i_x == '0) && (i_y == '0);
            state_reg <= PRE;
          end
        end
        PRE: begin
          // Fold the left half-plane onto the right so the rotations converge.
          if (x_reg[BITS-1] && !y_reg[BITS-1]) begin
            x_reg <= y_reg;
            y_reg <= -x_reg;
            z_reg <= HALF_PI;
          end else if (x_reg[BITS-1]) begin
            x_reg <= -y_reg;
            y_reg <= x_reg;
            z_reg <= -HALF_PI;
          end
          cnt_reg   <= '0;
          state_reg <= ITER;
        end
        ITER: begin
          if (y_reg[BITS-1]) begin
            x_reg <= x_reg - y_sh;
            y_reg <= y_reg + x_sh;
            z_reg <= z_reg - atan_tab[cnt_reg];
          end else begin
            x_reg <= x_reg + y_sh;
            y_reg <= y_reg - x_sh;
            z_reg <= z_reg + atan_tab[cnt_reg];
          end
          if (cnt_reg == CW'(N_ITERATION - 1)) begin
            cnt_reg   <= '0;
            state_reg <= SCALE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        SCALE: begin
          mag_reg   <= zero_reg ? '0 : BITS'(prod >>> FRACTIONAL_BITS);
          angle_reg <= zero_reg ? '0 : z_reg;
          state_reg <= DONE;
        end
        DONE: begin
          // o_valid rises one cycle after entering DONE, fixing latency at N_ITERATION+3.
          if (valid_reg && i_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end else begin
            valid_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Self-checking bench for cordic_vector_iter: directed cases, handshake corners and
// random vectors compared against real-valued sqrt/atan2 with the stated tolerances.
module tb_cordic_vector_iter;

  localparam int  BITS  = 33;
  localparam real SCALE = 1073741824.0;
  localparam real TOL   = 1.0 / 1024.0;
  localparam real PI    = 3.141592653589793;
  localparam int  LAT   = 15;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic                   i_valid = 1'b0;
  logic                   o_ready;
  logic signed [BITS-1:0] i_x = '0;
  logic signed [BITS-1:0] i_y = '0;
  logic                   o_valid;
  logic                   i_ready = 1'b0;
  logic signed [BITS-1:0] o_mag;
  logic signed [BITS-1:0] o_angle;

  int errors = 0;
  int checks = 0;

  cordic_vector_iter dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .i_y     (i_y),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_mag   (o_mag),
    .o_angle (o_angle)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic signed [BITS-1:0] to_fix(input real r);
    longint v;
    v = longint'(r * SCALE);
    return v[BITS-1:0];
  endfunction

  function automatic real to_real(input logic signed [BITS-1:0] v);
    longint w;
    w = v;
    return real'(w) / SCALE;
  endfunction

  function automatic real absr(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  function automatic real ang_err(input real got, input real exp);
    real e;
    e = got - exp;
    if (e > PI) e = e - 2.0 * PI;
    if (e < -PI) e = e + 2.0 * PI;
    return absr(e);
  endfunction

  // Drives one pair, waits (bounded) for the result; lat counts edges after the accept edge.
  task automatic send(input real xr, input real yr, input bit release_out,
                      output real mag_r, output real ang_r, output int lat);
    int waitc;
    waitc = 0;
    while (!o_ready && waitc < 50) begin
      @(posedge i_clk); #1;
      waitc++;
    end
    i_x = to_fix(xr);
    i_y = to_fix(yr);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    mag_r = to_real(o_mag);
    ang_r = to_real(o_angle);
    if (release_out) begin
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", o_ready); end
    checks++; if (o_mag !== '0) begin errors++; $display("FAIL reset_mag: got %0d expected 0", o_mag); end
    checks++; if (o_angle !== '0) begin errors++; $display("FAIL reset_angle: got %0d expected 0", o_angle); end
    i_rst_n = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", o_ready); end
  endtask

  task automatic test_directed();
    real xs [5] = '{1.0, 0.0, -1.0, -1.0, 0.6};
    real ys [5] = '{0.0, 1.0, -1.0, 0.0, 0.8};
    real m, a, qx, qy, em, ea;
    int  lat;
    for (int k = 0; k < 5; k++) begin
      send(xs[k], ys[k], 1'b1, m, a, lat);
      qx = to_real(to_fix(xs[k]));
      qy = to_real(to_fix(ys[k]));
      em = $sqrt(qx * qx + qy * qy);
      ea = $atan2(qy, qx);
      $display("directed %0d: x=%f y=%f mag=%f angle=%f lat=%0d", k, qx, qy, m, a, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, lat, LAT); end
      checks++; if (absr(m - em) > TOL * ((em > 1.0) ? em : 1.0)) begin errors++; $display("FAIL dir%0d_mag: got %f expected %f", k, m, em); end
      checks++; if (ang_err(a, ea) > TOL) begin errors++; $display("FAIL dir%0d_angle: got %f expected %f", k, a, ea); end
    end
  endtask

  task automatic test_zero();
    real m, a;
    int  lat;
    send(0.0, 0.0, 1'b1, m, a, lat);
    $display("zero: mag=%0d angle=%0d lat=%0d", o_mag, o_angle, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (o_mag !== '0) begin errors++; $display("FAIL zero_mag: got %0d expected 0", o_mag); end
    checks++; if (o_angle !== '0) begin errors++; $display("FAIL zero_angle: got %0d expected 0", o_angle); end
  endtask

  task automatic test_backpressure();
    real m, a, qx, qy;
    int  lat, spurious;
    logic signed [BITS-1:0] m0, a0;
    send(0.6, 0.8, 1'b0, m, a, lat);
    qx = to_real(to_fix(0.6));
    qy = to_real(to_fix(0.8));
    m0 = o_mag;
    a0 = o_angle;
    $display("backpressure: mag=%f angle=%f lat=%0d", m, a, lat);
    checks++; if (absr(m - $sqrt(qx * qx + qy * qy)) > TOL) begin errors++; $display("FAIL bp_mag: got %f expected %f", m, $sqrt(qx * qx + qy * qy)); end
    checks++; if (ang_err(a, $atan2(qy, qx)) > TOL) begin errors++; $display("FAIL bp_angle: got %f expected %f", a, $atan2(qy, qx)); end
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1;
      i_x = to_fix(-0.5 + 0.1 * c);
      i_y = to_fix(0.3);
      @(posedge i_clk); #1;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b expected 1", c, o_valid); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready%0d: got %b expected 0", c, o_ready); end
      checks++; if (o_mag !== m0 || o_angle !== a0) begin errors++; $display("FAIL bp_hold_data%0d: got %0d/%0d expected %0d/%0d", c, o_mag, o_angle, m0, a0); end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", o_ready); end
    checks++; if (o_mag !== m0) begin errors++; $display("FAIL bp_release_hold: got %0d expected %0d", o_mag, m0); end
    spurious = 0;
    repeat (20) begin
      @(posedge i_clk); #1;
      if (o_valid) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL bp_no_capture: got %0d valid cycles expected 0", spurious); end
  endtask

  task automatic test_reset_mid();
    real m, a, qx, qy;
    int  lat, spurious;
    i_x = to_fix(-0.5);
    i_y = to_fix(0.3);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (7) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    #1;
    $display("reset_mid: valid=%b ready=%b mag=%0d angle=%0d", o_valid, o_ready, o_mag, o_angle);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", o_ready); end
    checks++; if (o_mag !== '0 || o_angle !== '0) begin errors++; $display("FAIL rmid_outputs: got %0d/%0d expected 0/0", o_mag, o_angle); end
    spurious = 0;
    repeat (20) begin
      @(posedge i_clk); #1;
      if (o_valid) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL rmid_discard: got %0d valid cycles expected 0", spurious); end
    send(0.6, 0.8, 1'b1, m, a, lat);
    qx = to_real(to_fix(0.6));
    qy = to_real(to_fix(0.8));
    $display("after reset: mag=%f angle=%f lat=%0d", m, a, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rmid_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (absr(m - $sqrt(qx * qx + qy * qy)) > TOL) begin errors++; $display("FAIL rmid_mag: got %f expected %f", m, $sqrt(qx * qx + qy * qy)); end
    checks++; if (ang_err(a, $atan2(qy, qx)) > TOL) begin errors++; $display("FAIL rmid_angle: got %f expected %f", a, $atan2(qy, qx)); end
  endtask

  task automatic test_back_to_back();
    real xr, yr, r, m, a, qx, qy, em, ea;
    int  lat;
    for (int k = 0; k < 16; k++) begin
      xr = 0.0;
      yr = 0.0;
      for (int tries = 0; tries < 100; tries++) begin
        xr = (real'($urandom_range(0, 1000000)) / 1000000.0 - 0.5) * 2.8;
        yr = (real'($urandom_range(0, 1000000)) / 1000000.0 - 0.5) * 2.8;
        r  = $sqrt(xr * xr + yr * yr);
        if (r > 0.05 && r < 1.9) break;
        xr = 0.5;
        yr = -0.25;
      end
      send(xr, yr, 1'b1, m, a, lat);
      qx = to_real(to_fix(xr));
      qy = to_real(to_fix(yr));
      em = $sqrt(qx * qx + qy * qy);
      ea = $atan2(qy, qx);
      $display("random %0d: x=%f y=%f mag=%f/%f angle=%f/%f lat=%0d", k, qx, qy, m, em, a, ea, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", k, lat, LAT); end
      checks++; if (absr(m - em) > TOL * ((em > 1.0) ? em : 1.0)) begin errors++; $display("FAIL rnd%0d_mag: got %f expected %f", k, m, em); end
      checks++; if (ang_err(a, ea) > TOL) begin errors++; $display("FAIL rnd%0d_angle: got %f expected %f", k, a, ea); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
